// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 sequence transmit/detect blocks.
// State encoding and the default sync header live here.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int SYNC_W_DEF = 4;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PATTERN_DEF = 4'b1011;

    // Bits needed to count down from the largest of three lengths.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shift register, MSB first.
// Reusable by any serial transmitter.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] data_in,
    output logic         msb
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= data_in;
        end else if (shift_en) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header, MSB-first payload, idle gap.
// Transmit-side partner of the 1011 sequence detector.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int                GAP_LEN      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              stall,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frames_sent
);

    localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP_LEN);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [7:0]       sent_q;
    logic             accept;
    logic             load;
    logic             shift_en;
    logic             sync_bit;
    logic             data_msb;

    piso_shift #(.W(DATA_W)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .data_in  (data_in),
        .msb      (data_msb)
    );

    assign data_ready = (state_q == IDLE);
    assign accept     = data_valid && data_ready;
    assign busy       = (state_q != IDLE);
    assign out_valid  = ((state_q == SYNC) || (state_q == DATA)) && !stall;
    assign frame_done = done_q;
    assign frames_sent = sent_q;

    // Select the header bit by counter without a width-mismatched index.
    always_comb begin
        sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (cnt_q == CNT_W'(i)) sync_bit = SYNC_PATTERN[i];
        end
    end

    always_comb begin
        out_bit = 1'b0;
        unique case (state_q)
            SYNC:    out_bit = sync_bit;
            DATA:    out_bit = data_msb;
            default: out_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = SYNC;
                    cnt_d   = CNT_W'(SYNC_W - 1);
                end
            end
            SYNC: begin
                if (out_valid) begin
                    if (cnt_q == '0) begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(DATA_W - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (out_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == '0) begin
                        done_d = 1'b1;
                        if (GAP_LEN == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(GAP_LEN - 1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                // Gap time runs even while stalled.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sent_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (done_d) sent_q <= sent_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: default build plus a DATA_W=1, GAP_LEN=0 build.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       stall;
    logic       data_ready;
    logic       out_bit;
    logic       out_valid;
    logic       busy;
    logic       frame_done;
    logic [7:0] frames_sent;

    logic [0:0] d1_in;
    logic       d1_valid;
    logic       d1_stall;
    logic       d1_ready;
    logic       d1_bit;
    logic       d1_ov;
    logic       d1_busy;
    logic       d1_done;
    logic [7:0] d1_sent;

    int checks = 0;
    int passed = 0;

    logic [63:0] ov, ob, dr, fd, bz, bits;
    int nbits, done_cnt, done_at, ready_at;

    seq_frame_tx #(
        .DATA_W(8), .SYNC_W(4), .SYNC_PATTERN(4'b1011), .GAP_LEN(2)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .stall(stall),
        .out_bit(out_bit), .out_valid(out_valid), .busy(busy),
        .frame_done(frame_done), .frames_sent(frames_sent)
    );

    seq_frame_tx #(
        .DATA_W(1), .GAP_LEN(0)
    ) dut1 (
        .clk(clk), .reset(reset), .data_in(d1_in),
        .data_valid(d1_valid), .data_ready(d1_ready), .stall(d1_stall),
        .out_bit(d1_bit), .out_valid(d1_ov), .busy(d1_busy),
        .frame_done(d1_done), .frames_sent(d1_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Runs n cycles of dut, recording per-cycle outputs; drops data_valid after accepts.
    task automatic capture(input int n, input logic [63:0] smask,
                           input bit hold, input logic [7:0] next_word);
        logic rdy_prev;
        int   acc;
        ov = '0; ob = '0; dr = '0; fd = '0; bz = '0; bits = '0;
        nbits = 0; done_cnt = 0; done_at = -1; ready_at = -1; acc = 0;
        rdy_prev = data_ready;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (data_valid && rdy_prev) begin
                acc++;
                if (hold && acc == 1) data_in = next_word;
                else data_valid = 1'b0;
            end
            stall = smask[i];
            @(negedge clk);
            ov[i] = out_valid; ob[i] = out_bit; dr[i] = data_ready;
            fd[i] = frame_done; bz[i] = busy;
            if (out_valid) begin
                bits = {bits[62:0], out_bit};
                nbits++;
            end
            if (frame_done) begin
                done_cnt++;
                done_at = i;
            end
            if (data_ready && ready_at < 0) ready_at = i;
            rdy_prev = data_ready;
        end
        stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_valid = 1'b0; stall = 1'b0; data_in = 8'h00;
        d1_valid = 1'b0; d1_stall = 1'b0; d1_in = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_bit !== 1'b0) $display("FAIL reset_out_bit: got %b want 0", out_bit); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
        checks++; if (frames_sent !== 8'd0) $display("FAIL reset_frames_sent: got %0d want 0", frames_sent); else passed++;
        checks++; if (data_ready !== 1'b1) $display("FAIL reset_data_ready: got %b want 1", data_ready); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        data_in = 8'hA5; data_valid = 1'b1;
        capture(16, 64'd0, 1'b0, 8'h00);
        checks++; if (nbits !== 12) $display("FAIL basic_nbits: got %0d want 12", nbits); else passed++;
        checks++; if (bits[11:0] !== 12'hBA5) $display("FAIL basic_stream: got %h want ba5", bits[11:0]); else passed++;
        checks++; if (ov[13:12] !== 2'b00) $display("FAIL basic_gap_valid: got %b want 00", ov[13:12]); else passed++;
        checks++; if (ob[13:12] !== 2'b00) $display("FAIL basic_gap_bit: got %b want 00", ob[13:12]); else passed++;
        checks++; if (bz[0] !== 1'b1) $display("FAIL basic_busy: got %b want 1", bz[0]); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else passed++;
        checks++; if (done_at !== 12) $display("FAIL basic_done_at: got %0d want 12", done_at); else passed++;
        checks++; if (ready_at !== 14) $display("FAIL basic_ready_at: got %0d want 14", ready_at); else passed++;
        checks++; if (frames_sent !== 8'd1) $display("FAIL basic_frames_sent: got %0d want 1", frames_sent); else passed++;
    endtask

    task automatic test_stall();
        data_in = 8'hA5; data_valid = 1'b1;
        capture(20, 64'h1C0, 1'b0, 8'h00);
        checks++; if (nbits !== 12) $display("FAIL stall_nbits: got %0d want 12", nbits); else passed++;
        checks++; if (bits[11:0] !== 12'hBA5) $display("FAIL stall_stream: got %h want ba5", bits[11:0]); else passed++;
        checks++; if (ov[8:6] !== 3'b000) $display("FAIL stall_valid: got %b want 000", ov[8:6]); else passed++;
        checks++; if (ob[8:6] !== 3'b111) $display("FAIL stall_held_bit: got %b want 111", ob[8:6]); else passed++;
        checks++; if (done_at !== 15) $display("FAIL stall_done_at: got %0d want 15", done_at); else passed++;
        checks++; if (ready_at !== 17) $display("FAIL stall_ready_at: got %0d want 17", ready_at); else passed++;
        checks++; if (frames_sent !== 8'd2) $display("FAIL stall_frames_sent: got %0d want 2", frames_sent); else passed++;
    endtask

    task automatic test_back_to_back();
        data_in = 8'h00; data_valid = 1'b1;
        capture(32, 64'd0, 1'b1, 8'hFF);
        checks++; if (nbits !== 24) $display("FAIL b2b_nbits: got %0d want 24", nbits); else passed++;
        checks++; if (bits[23:0] !== 24'hB00BFF) $display("FAIL b2b_stream: got %h want b00bff", bits[23:0]); else passed++;
        checks++; if (ov[15:12] !== 4'b1000) $display("FAIL b2b_gap: got %b want 1000", ov[15:12]); else passed++;
        checks++; if (done_cnt !== 2) $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); else passed++;
        checks++; if (frames_sent !== 8'd4) $display("FAIL b2b_frames_sent: got %0d want 4", frames_sent); else passed++;
    endtask

    task automatic test_reset_mid();
        data_in = 8'hA5; data_valid = 1'b1;
        capture(8, 64'd0, 1'b0, 8'h00);
        checks++; if (ov[7] !== 1'b1 || bz[7] !== 1'b1) $display("FAIL mid_pre_state: got ov=%b busy=%b want 1 1", ov[7], bz[7]); else passed++;
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        checks++; if (frames_sent !== 8'd0) $display("FAIL mid_frames_sent: got %0d want 0", frames_sent); else passed++;
        checks++; if (data_ready !== 1'b1) $display("FAIL mid_data_ready: got %b want 1", data_ready); else passed++;
        #1 reset = 1'b0;
        capture(6, 64'd0, 1'b0, 8'h00);
        checks++; if (done_cnt !== 0 || ov[5:0] !== 6'd0) $display("FAIL mid_no_done: got done=%0d ov=%b want 0 0", done_cnt, ov[5:0]); else passed++;
        data_in = 8'h3C; data_valid = 1'b1;
        capture(16, 64'd0, 1'b0, 8'h00);
        checks++; if (bits[11:0] !== 12'hB3C || nbits !== 12) $display("FAIL mid_next_stream: got %h/%0d want b3c/12", bits[11:0], nbits); else passed++;
        checks++; if (frames_sent !== 8'd1) $display("FAIL mid_next_count: got %0d want 1", frames_sent); else passed++;
    endtask

    task automatic test_wrap();
        logic       rdy_prev;
        int         acc;
        int         pulses;
        logic [7:0] fs255;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        acc = 0; pulses = 0; fs255 = 8'hXX;
        data_in = 8'h96; data_valid = 1'b1;
        rdy_prev = data_ready;
        for (int i = 0; i < 256 * 15 + 30; i++) begin
            @(posedge clk); #1;
            if (data_valid && rdy_prev) begin
                acc++;
                if (acc == 256) data_valid = 1'b0;
            end
            @(negedge clk);
            if (frame_done) begin
                pulses++;
                if (pulses == 255) fs255 = frames_sent;
            end
            rdy_prev = data_ready;
        end
        checks++; if (acc !== 256) $display("FAIL wrap_accepts: got %0d want 256", acc); else passed++;
        checks++; if (pulses !== 256) $display("FAIL wrap_pulses: got %0d want 256", pulses); else passed++;
        checks++; if (fs255 !== 8'd255) $display("FAIL wrap_at_255: got %0d want 255", fs255); else passed++;
        checks++; if (frames_sent !== 8'd0) $display("FAIL wrap_count: got %0d want 0", frames_sent); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL wrap_idle: got %b want 0", busy); else passed++;
    endtask

    task automatic test_short_frame();
        logic rdy_prev;
        ov = '0; fd = '0; dr = '0; bz = '0; bits = '0; nbits = 0;
        d1_in = 1'b1; d1_valid = 1'b1;
        rdy_prev = d1_ready;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (d1_valid && rdy_prev) d1_valid = 1'b0;
            @(negedge clk);
            ov[i] = d1_ov; fd[i] = d1_done; dr[i] = d1_ready; bz[i] = d1_busy;
            if (d1_ov) begin
                bits = {bits[62:0], d1_bit};
                nbits++;
            end
            rdy_prev = d1_ready;
        end
        checks++; if (bits[4:0] !== 5'b10111 || nbits !== 5) $display("FAIL short_stream: got %b/%0d want 10111/5", bits[4:0], nbits); else passed++;
        checks++; if (dr[5:4] !== 2'b10 || bz[4] !== 1'b1) $display("FAIL short_ready: got %b busy=%b want 10 1", dr[5:4], bz[4]); else passed++;
        checks++; if (fd[5:4] !== 2'b10 || ov[5] !== 1'b0) $display("FAIL short_done: got %b ov=%b want 10 0", fd[5:4], ov[5]); else passed++;
        checks++; if (d1_sent !== 8'd1) $display("FAIL short_count: got %0d want 1", d1_sent); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_short_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
